// File: rtl/updown_counter_fsm.sv
// Parametrised up/down event counter with a small control FSM (IDLE/UP/DN/HALT).
// Boundary behaviour at 0 / MAX_VAL is selected by MODE: sticky halt, wrap or saturate.
module updown_counter_fsm #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 2**WIDTH-1,
   parameter int MODE    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             act,
   input  logic             up_down,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             overflow,
   output logic             underflow,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic             STICKY   = (MODE == 0);
   localparam logic             WRAP     = (MODE == 1);

   state_t st;

   // Loads above the terminal value are clamped so the count never leaves [0, MAX_VAL].
   function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
      return (val > MAX_CNT) ? MAX_CNT : val;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         st        <= IDLE;
      end else if (clr) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         st        <= IDLE;
      end else if (load) begin
         count     <= clamp_load(load_val);
         overflow  <= 1'b0;
         underflow <= 1'b0;
         st        <= IDLE;
      end else if (st == HALT) begin
         // Sticky halt: everything frozen until clr, load or reset.
         st <= HALT;
      end else if (!act) begin
         st <= IDLE;
         if (!STICKY) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
      end else if (up_down) begin
         underflow <= 1'b0;
         if (count < MAX_CNT) begin
            count    <= count + ONE;
            overflow <= 1'b0;
            st       <= UP;
         end else begin
            overflow <= 1'b1;
            if (STICKY) begin
               st <= HALT;
            end else begin
               st <= UP;
               if (WRAP) count <= '0;
            end
         end
      end else begin
         overflow <= 1'b0;
         if (count != '0) begin
            count     <= count - ONE;
            underflow <= 1'b0;
            st        <= DN;
         end else begin
            underflow <= 1'b1;
            if (STICKY) begin
               st <= HALT;
            end else begin
               st <= DN;
               if (WRAP) count <= MAX_CNT;
            end
         end
      end
   end

   assign state = st;

endmodule

// File: tb/tb_updown_counter_fsm.sv
// Directed bench for updown_counter_fsm: four instances share stimulus, each
// configured for one boundary mode / terminal value under test.
module tb_updown_counter_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       act = 1'b0;
   logic       up_down = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] c0, c1, c2, c3;
   logic       o0, o1, o2, o3;
   logic       u0, u1, u2, u3;
   logic [1:0] s0, s1, s2, s3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // d0: sticky, full range; d1: sticky, MAX 9; d2: wrap, MAX 9; d3: saturate, full range
   updown_counter_fsm #(.WIDTH(4), .MAX_VAL(15), .MODE(0)) d0 (
      .clk(clk), .reset(reset), .act(act), .up_down(up_down), .clr(clr), .load(load),
      .load_val(load_val), .count(c0), .overflow(o0), .underflow(u0), .state(s0));
   updown_counter_fsm #(.WIDTH(4), .MAX_VAL(9), .MODE(0)) d1 (
      .clk(clk), .reset(reset), .act(act), .up_down(up_down), .clr(clr), .load(load),
      .load_val(load_val), .count(c1), .overflow(o1), .underflow(u1), .state(s1));
   updown_counter_fsm #(.WIDTH(4), .MAX_VAL(9), .MODE(1)) d2 (
      .clk(clk), .reset(reset), .act(act), .up_down(up_down), .clr(clr), .load(load),
      .load_val(load_val), .count(c2), .overflow(o2), .underflow(u2), .state(s2));
   updown_counter_fsm #(.WIDTH(4), .MAX_VAL(15), .MODE(2)) d3 (
      .clk(clk), .reset(reset), .act(act), .up_down(up_down), .clr(clr), .load(load),
      .load_val(load_val), .count(c3), .overflow(o3), .underflow(u3), .state(s3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic a, input logic ud, input logic c, input logic l,
                         input logic [3:0] lv);
      act = a; up_down = ud; clr = c; load = l; load_val = lv;
   endtask

   // {count, overflow, underflow, state}
   task automatic test_reset;
      logic [7:0] exp;
      #1;
      exp = {4'd0, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c0, o0, u0, s0} !== exp) begin
         errors++; $display("FAIL reset_initial: got %h want %h", {c0, o0, u0, s0}, exp);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      set_in(1, 1, 0, 0, 4'd0);
      for (int i = 0; i < 7; i++) tick();
      exp = {4'd7, 1'b0, 1'b0, 2'd1};
      checks++;
      if ({c0, o0, u0, s0} !== exp) begin
         errors++; $display("FAIL reset_count7: got %h want %h", {c0, o0, u0, s0}, exp);
      end
      #2 reset = 1'b0;
      #1;
      exp = {4'd0, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c0, o0, u0, s0} !== exp) begin
         errors++; $display("FAIL reset_async: got %h want %h", {c0, o0, u0, s0}, exp);
      end
      tick();
      checks++;
      if ({c0, o0, u0, s0} !== exp) begin
         errors++; $display("FAIL reset_held: got %h want %h", {c0, o0, u0, s0}, exp);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      exp = {4'd5, 1'b0, 1'b0, 2'd1};
      checks++;
      if ({c0, o0, u0, s0} !== exp) begin
         errors++; $display("FAIL reset_release_up5: got %h want %h", {c0, o0, u0, s0}, exp);
      end
   endtask

   task automatic test_sticky;
      logic [7:0] exp;
      set_in(0, 0, 0, 1, 4'd8); tick();
      exp = {4'd8, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_load8: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(1, 1, 0, 0, 4'd0); tick();
      exp = {4'd9, 1'b0, 1'b0, 2'd1};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_up_to9: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      tick();
      exp = {4'd9, 1'b1, 1'b0, 2'd3};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_halt: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      tick();
      set_in(1, 0, 0, 0, 4'd0); tick();
      set_in(0, 0, 0, 0, 4'd0); tick();
      set_in(1, 0, 0, 0, 4'd0); tick();
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_ignores_act: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(0, 0, 1, 0, 4'd0); tick();
      exp = {4'd0, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_clr: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(1, 0, 0, 0, 4'd0); tick();
      exp = {4'd0, 1'b0, 1'b1, 2'd3};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL sticky_underflow: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(0, 0, 1, 0, 4'd0); tick();
   endtask

   task automatic test_wrap;
      logic [7:0] exp;
      set_in(0, 0, 0, 1, 4'd9); tick();
      set_in(1, 1, 0, 0, 4'd0); tick();
      exp = {4'd0, 1'b1, 1'b0, 2'd1};
      checks++;
      if ({c2, o2, u2, s2} !== exp) begin
         errors++; $display("FAIL wrap_up: got %h want %h", {c2, o2, u2, s2}, exp);
      end
      tick();
      exp = {4'd1, 1'b0, 1'b0, 2'd1};
      checks++;
      if ({c2, o2, u2, s2} !== exp) begin
         errors++; $display("FAIL wrap_ovf_one_cycle: got %h want %h", {c2, o2, u2, s2}, exp);
      end
      set_in(1, 0, 0, 0, 4'd0); tick(); tick();
      exp = {4'd9, 1'b0, 1'b1, 2'd2};
      checks++;
      if ({c2, o2, u2, s2} !== exp) begin
         errors++; $display("FAIL wrap_down: got %h want %h", {c2, o2, u2, s2}, exp);
      end
      set_in(0, 0, 0, 0, 4'd0); tick();
      exp = {4'd9, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c2, o2, u2, s2} !== exp) begin
         errors++; $display("FAIL wrap_unf_drop: got %h want %h", {c2, o2, u2, s2}, exp);
      end
   endtask

   task automatic test_saturate;
      logic [7:0] exp;
      set_in(0, 0, 0, 1, 4'd1); tick();
      set_in(1, 0, 0, 0, 4'd0); tick();
      exp = {4'd0, 1'b0, 1'b0, 2'd2};
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_down1: got %h want %h", {c3, o3, u3, s3}, exp);
      end
      tick();
      exp = {4'd0, 1'b0, 1'b1, 2'd2};
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_down2: got %h want %h", {c3, o3, u3, s3}, exp);
      end
      tick();
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_down3: got %h want %h", {c3, o3, u3, s3}, exp);
      end
      set_in(1, 1, 0, 0, 4'd0); tick();
      exp = {4'd1, 1'b0, 1'b0, 2'd1};
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_up_release: got %h want %h", {c3, o3, u3, s3}, exp);
      end
      set_in(0, 0, 0, 1, 4'd15); tick();
      set_in(1, 1, 0, 0, 4'd0); tick();
      exp = {4'd15, 1'b1, 1'b0, 2'd1};
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_overflow: got %h want %h", {c3, o3, u3, s3}, exp);
      end
      set_in(0, 1, 0, 0, 4'd0); tick();
      exp = {4'd15, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c3, o3, u3, s3} !== exp) begin
         errors++; $display("FAIL sat_ovf_drop: got %h want %h", {c3, o3, u3, s3}, exp);
      end
   endtask

   task automatic test_priority;
      logic [7:0] exp;
      set_in(1, 1, 0, 1, 4'd12); tick();
      exp = {4'd9, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL prio_load_clamp: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(1, 1, 0, 0, 4'd0); tick();
      set_in(1, 1, 0, 1, 4'd3); tick();
      exp = {4'd3, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL prio_load_exits_halt: got %h want %h", {c1, o1, u1, s1}, exp);
      end
      set_in(1, 1, 1, 1, 4'd5); tick();
      exp = {4'd0, 1'b0, 1'b0, 2'd0};
      checks++;
      if ({c1, o1, u1, s1} !== exp) begin
         errors++; $display("FAIL prio_clr_over_load: got %h want %h", {c1, o1, u1, s1}, exp);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp;
      logic [3:0] cnt_exp [4] = '{4'd6, 4'd5, 4'd6, 4'd5};
      logic [1:0] st_exp  [4] = '{2'd1, 2'd2, 2'd1, 2'd2};
      set_in(0, 0, 0, 1, 4'd5); tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1, (i % 2 == 0), 0, 0, 4'd0); tick();
         exp = {cnt_exp[i], 1'b0, 1'b0, st_exp[i]};
         checks++;
         if ({c0, o0, u0, s0} !== exp) begin
            errors++; $display("FAIL reversal_%0d: got %h want %h", i, {c0, o0, u0, s0}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sticky();
      test_wrap();
      test_saturate();
      test_priority();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
